data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word-addressed RAM plus a small MMIO window
// (LED, switches, seven-segment number, free-running timer with compare irq).
module data_sram_resp #(
    parameter int unsigned RAM_WORDS    = 4096,
    parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] switch_i,
    output logic [15:0] led_o,
    output logic [31:0] num_o,
    output logic        timer_irq_o
);
    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [13:0] OFF_LED  = 14'h0;
    localparam logic [13:0] OFF_SW   = 14'h1;
    localparam logic [13:0] OFF_NUM  = 14'h2;
    localparam logic [13:0] OFF_TMR  = 14'h3;
    localparam logic [13:0] OFF_CMP  = 14'h4;
    localparam logic [13:0] OFF_STAT = 14'h5;

    logic [31:0] ram_q [RAM_WORDS];

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        irq_q, irq_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    logic          is_mmio, wr, rd;
    logic [13:0]   off;
    logic [AW-1:0] widx;
    logic [31:0]   bmask, mmio_rdata;
    logic          irq_set, irq_clr;
    logic [1:0]    unused_addr_lsb;

    assign is_mmio         = (data_sram_addr[31:16] == MMIO_BASE_HI);
    assign off             = data_sram_addr[15:2];
    assign widx            = data_sram_addr[AW+1:2];
    assign wr              = data_sram_en && (data_sram_wen != 4'b0000);
    assign rd              = data_sram_en && (data_sram_wen == 4'b0000);
    assign unused_addr_lsb = data_sram_addr[1:0];

    assign bmask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                    {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    always_comb begin
        mmio_rdata = 32'h0;
        case (off)
            OFF_LED:  mmio_rdata = {16'h0, led_q};
            OFF_SW:   mmio_rdata = {16'h0, sw_sync_q};
            OFF_NUM:  mmio_rdata = num_q;
            OFF_TMR:  mmio_rdata = timer_q;
            OFF_CMP:  mmio_rdata = cmp_q;
            OFF_STAT: mmio_rdata = {31'h0, irq_q};
            default:  mmio_rdata = 32'h0;
        endcase
    end

    // Compare uses the pre-increment timer; a set in the same cycle as a clear wins.
    assign irq_set = (cmp_q != 32'h0) && (timer_q == cmp_q);
    assign irq_clr = wr && is_mmio && (off == OFF_STAT)
                     && data_sram_wen[0] && data_sram_wdata[0];

    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        num_d   = num_q;
        timer_d = timer_q + 32'd1;
        cmp_d   = cmp_q;
        irq_d   = irq_set | (irq_q & ~irq_clr);
        if (rd)
            rdata_d = is_mmio ? mmio_rdata : ram_q[widx];
        if (wr && is_mmio) begin
            case (off)
                OFF_LED: led_d   = (led_q & ~bmask[15:0]) | (data_sram_wdata[15:0] & bmask[15:0]);
                OFF_NUM: num_d   = merge(num_q, data_sram_wdata, bmask);
                OFF_TMR: timer_d = merge(timer_q, data_sram_wdata, bmask);
                OFF_CMP: cmp_d   = merge(cmp_q, data_sram_wdata, bmask);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= 32'h0;
            led_q     <= 16'h0;
            num_q     <= 32'h0;
            timer_q   <= 32'h0;
            cmp_q     <= 32'h0;
            irq_q     <= 1'b0;
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            irq_q     <= irq_d;
            sw_meta_q <= switch_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM contents survive reset; only the access in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr && !is_mmio) begin
            for (int b = 0; b < 4; b++)
                if (data_sram_wen[b])
                    ram_q[widx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led_o           = led_q;
    assign num_o           = num_q;
    assign timer_irq_o     = irq_q;

endmodule
